// File: rtl/jtopl_eg_adsr_if.sv
// Register-map inputs, envelope-counter strobe and attenuation outputs
// for one OPL operator envelope generator.
interface jtopl_eg_adsr_if;
  logic        cen;
  logic        zero;
  logic [14:0] eg_cnt;
  logic        keyon;
  logic [3:0]  ar;
  logic [3:0]  dr;
  logic [3:0]  sl;
  logic [3:0]  rr;
  logic [3:0]  ksr_off;
  logic        eg_type;
  logic [8:0]  eg_level;
  logic [1:0]  eg_state;
  logic        eg_stp;

  modport master (
    output cen, zero, eg_cnt, keyon, ar, dr, sl, rr, ksr_off, eg_type,
    input  eg_level, eg_state, eg_stp
  );

  modport slave (
    input  cen, zero, eg_cnt, keyon, ar, dr, sl, rr, ksr_off, eg_type,
    output eg_level, eg_state, eg_stp
  );
endinterface

// File: rtl/jtopl_eg_adsr.sv
// OPL operator envelope generator: ADSR state machine driving a 9-bit
// attenuation (0 loudest, 511 silent), advanced only on envelope ticks.
//
// state   | meaning
// ATTACK  | level falls exponentially towards 0
// DECAY   | level rises linearly towards the sustain target
// SUSTAIN | hold (eg_type=1) or keep rising at the release rate
// RELEASE | level rises linearly towards 511
module jtopl_eg_adsr (
  input logic            clk,
  input logic            rst,
  jtopl_eg_adsr_if.slave eg
);

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [8:0]  level, level_nx;
  logic        stp, stp_nx;
  logic        keyon_last, keyon_last_nx;

  logic        tick;
  logic [3:0]  rsel;
  logic [6:0]  rate_sum;
  logic [5:0]  rate;
  logic [3:0]  rh;
  logic [1:0]  rl;
  logic [7:0]  pat;
  logic [3:0]  sh;
  logic [14:0] low_mask;
  logic [2:0]  pat_idx;
  logic [3:0]  base;
  logic [3:0]  inc;
  logic [11:0] prod;
  logic [8:0]  dec;
  logic [9:0]  sum;
  logic [8:0]  tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RELEASE;
      level      <= 9'd511;
      stp        <= 1'b0;
      keyon_last <= 1'b0;
    end else begin
      state      <= state_nx;
      level      <= level_nx;
      stp        <= stp_nx;
      keyon_last <= keyon_last_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    level_nx      = level;
    stp_nx        = 1'b0;
    keyon_last_nx = keyon_last;

    tick = eg.cen & eg.zero;

    case (state)
      ATTACK:  rsel = eg.ar;
      DECAY:   rsel = eg.dr;
      SUSTAIN: rsel = eg.eg_type ? 4'd0 : eg.rr;
      default: rsel = eg.rr;
    endcase

    rate_sum = {1'b0, rsel, 2'b00} + {3'b000, eg.ksr_off};
    if (rsel == 4'd0)          rate = 6'd0;
    else if (rate_sum > 7'd63) rate = 6'd63;
    else                       rate = rate_sum[5:0];
    rh = rate[5:2];
    rl = rate[1:0];

    case (rl)
      2'd0:    pat = 8'b10101010;
      2'd1:    pat = 8'b11101010;
      2'd2:    pat = 8'b11101110;
      default: pat = 8'b11111110;
    endcase

    // Slow rates step once every 2^sh ticks, gated by the 3 counter bits above
    sh       = 4'd12 - rh;
    low_mask = (15'd1 << sh) - 15'd1;
    pat_idx  = 3'(eg.eg_cnt >> sh);
    base     = 4'd1 << (rh - 4'd12);

    inc = 4'd0;
    if (rate != 6'd0) begin
      if (rh < 4'd12) begin
        if (((eg.eg_cnt & low_mask) == 15'd0) && pat[pat_idx]) inc = 4'd1;
      end else if (rh == 4'd15) begin
        inc = 4'd8;
      end else begin
        inc = pat[eg.eg_cnt[2:0]] ? (base << 1) : base;
      end
    end

    prod = {3'd0, level} * {8'd0, inc};
    dec  = 9'(prod >> 3);
    if (dec == 9'd0) dec = 9'd1;
    sum  = {1'b0, level} + {6'd0, inc};
    tgt  = (eg.sl == 4'd15) ? {5'd31, 4'd0} : {1'b0, eg.sl, 4'd0};

    if (tick) begin
      keyon_last_nx = eg.keyon;
      if (eg.keyon && !keyon_last) begin
        state_nx = ATTACK;
      end else if (!eg.keyon && keyon_last) begin
        state_nx = RELEASE;
      end else if (state == ATTACK && level == 9'd0) begin
        state_nx = DECAY;
      end else if (state == DECAY && level >= tgt) begin
        state_nx = SUSTAIN;
      end else if (inc != 4'd0) begin
        if (state == ATTACK) begin
          if (rate >= 6'd60)   level_nx = 9'd0;
          else if (dec > level) level_nx = 9'd0;
          else                  level_nx = level - dec;
        end else begin
          level_nx = sum[9] ? 9'd511 : sum[8:0];
        end
        stp_nx = (level_nx != level);
      end
    end
  end

  assign eg.eg_level = level;
  assign eg.eg_state = state;
  assign eg.eg_stp   = stp;

endmodule

// File: tb/tb_jtopl_eg_adsr.sv
// Self-checking bench for jtopl_eg_adsr: vector table, directed corner
// sequences and a randomized run against an arithmetic reference model.
module tb_jtopl_eg_adsr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtopl_eg_adsr_if eg();
  jtopl_eg_adsr dut (.clk(clk), .rst(rst), .eg(eg));

  int n_chk  = 0;
  int n_fail = 0;

  int pats[4] = '{170, 234, 238, 254};
  int m_level, m_state, m_stp, m_kl;

  typedef struct {
    int tick, keyon, ar, dr, sl, rr, typ, cnt, lvl, st, stp;
  } vec_t;
  vec_t vt[20];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check3(input string tag, input int lvl, input int st, input int stp);
    check({tag, ".level"}, int'(eg.eg_level), lvl);
    check({tag, ".state"}, int'(eg.eg_state), st);
    check({tag, ".stp"},   int'(eg.eg_stp),   stp);
  endtask

  function automatic int model_inc(input int rate, input int cnt);
    int rh, rl, sh, pat, base;
    if (rate == 0) return 0;
    rh  = rate / 4;
    rl  = rate % 4;
    pat = pats[rl];
    if (rh < 12) begin
      sh = 12 - rh;
      if ((cnt % (1 << sh)) == 0 && ((pat >> ((cnt >> sh) % 8)) % 2) == 1) return 1;
      return 0;
    end
    if (rh == 15) return 8;
    base = 1 << (rh - 12);
    return (((pat >> (cnt % 8)) % 2) == 1) ? 2 * base : base;
  endfunction

  task automatic model_reset();
    m_level = 511; m_state = 3; m_stp = 0; m_kl = 0;
  endtask

  // Uses the inputs present just before the coming clock edge
  task automatic model_clk();
    int r, rate, inc, nl, tgt, d, k;
    m_stp = 0;
    if (eg.cen && eg.zero) begin
      k = int'(eg.keyon);
      case (m_state)
        0:       r = int'(eg.ar);
        1:       r = int'(eg.dr);
        2:       r = eg.eg_type ? 0 : int'(eg.rr);
        default: r = int'(eg.rr);
      endcase
      rate = 4 * r + int'(eg.ksr_off);
      if (r == 0) rate = 0;
      else if (rate > 63) rate = 63;
      inc = model_inc(rate, int'(eg.eg_cnt));
      tgt = (eg.sl == 4'd15) ? 496 : 16 * int'(eg.sl);
      if (k == 1 && m_kl == 0)            m_state = 0;
      else if (k == 0 && m_kl == 1)       m_state = 3;
      else if (m_state == 0 && m_level == 0) m_state = 1;
      else if (m_state == 1 && m_level >= tgt) m_state = 2;
      else if (inc > 0) begin
        if (m_state == 0) begin
          if (rate >= 60) nl = 0;
          else begin
            d = (m_level * inc) / 8;
            if (d == 0) d = 1;
            nl = (m_level > d) ? m_level - d : 0;
          end
        end else begin
          nl = (m_level + inc > 511) ? 511 : m_level + inc;
        end
        m_stp   = (nl != m_level) ? 1 : 0;
        m_level = nl;
      end
      m_kl = k;
    end
  endtask

  task automatic cyc();
    model_clk();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic tk(input int cnt);
    eg.cen = 1'b1; eg.zero = 1'b1; eg.eg_cnt = 15'(cnt);
    cyc();
  endtask

  task automatic set_regs(input int ar, input int dr, input int sl, input int rr, input int typ);
    eg.ar = 4'(ar); eg.dr = 4'(dr); eg.sl = 4'(sl); eg.rr = 4'(rr); eg.eg_type = typ[0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    eg.keyon = 1'b0; eg.cen = 1'b0; eg.zero = 1'b0; eg.eg_cnt = '0;
    set_regs(0, 0, 0, 0, 0);
    eg.ksr_off = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int stp_seen, cnt, exp_lvl;
    int seq5_lvl[3] = '{504, 511, 511};
    int seq5_stp[3] = '{1, 1, 0};

    vt[0]  = '{1,1,15, 0,2, 0,1, 0,511,0,0};
    vt[1]  = '{1,1,15, 0,2, 0,1, 0,  0,0,1};
    vt[2]  = '{0,1,15, 0,2, 0,1, 0,  0,0,0};
    vt[3]  = '{1,1,15, 0,2, 0,1, 0,  0,1,0};
    vt[4]  = '{1,1,15,15,2, 0,1, 0,  8,1,1};
    vt[5]  = '{1,1,15,15,2, 0,1, 0, 16,1,1};
    vt[6]  = '{1,1,15,15,2, 0,1, 0, 24,1,1};
    vt[7]  = '{1,1,15,15,2, 0,1, 0, 32,1,1};
    vt[8]  = '{1,1,15,15,2, 0,1, 0, 32,2,0};
    vt[9]  = '{1,1,15,15,2, 0,1, 0, 32,2,0};
    vt[10] = '{1,0,15,15,2, 0,1, 0, 32,3,0};
    vt[11] = '{1,0,15,15,2,15,1, 0, 40,3,1};
    vt[12] = '{1,0,15,15,2, 0,1, 0, 40,3,0};
    vt[13] = '{1,1, 0,15,2, 0,1, 0, 40,0,0};
    vt[14] = '{1,1, 8,15,2, 0,1,16, 35,0,1};
    vt[15] = '{1,1, 8,15,2, 0,1,32, 35,0,0};
    vt[16] = '{1,1,13,15,2, 0,1, 1, 18,0,1};
    vt[17] = '{1,1,13,15,2, 0,1, 0, 14,0,1};
    vt[18] = '{1,1,12,15,2, 0,1, 0, 13,0,1};
    vt[19] = '{1,1,12,15,2, 0,1, 3, 10,0,1};

    do_reset();
    check3("reset", 511, 3, 0);

    for (int i = 0; i < 20; i++) begin
      eg.keyon = vt[i].keyon[0];
      set_regs(vt[i].ar, vt[i].dr, vt[i].sl, vt[i].rr, vt[i].typ);
      eg.cen = 1'b1; eg.zero = vt[i].tick[0]; eg.eg_cnt = 15'(vt[i].cnt);
      cyc();
      check3($sformatf("vec%0d", i), vt[i].lvl, vt[i].st, vt[i].stp);
    end

    // Slow attack: first step at eg_cnt 0x100, then async reset mid-attack
    do_reset();
    set_regs(4, 0, 0, 0, 0);
    eg.keyon = 1'b1;
    tk(0);      check3("ar4.keyon", 511, 0, 0);
    tk('h80);   check3("ar4.nostep", 511, 0, 0);
    tk('h100);  check3("ar4.step", 448, 0, 1);
    tk('h101);  check3("ar4.after", 448, 0, 0);
    #2 rst = 1'b1;
    #1 check3("async_rst", 511, 3, 0);
    @(negedge clk);
    rst = 1'b0;

    // Decay to sl=15 target, long hold, then release-rate creep to saturation
    do_reset();
    set_regs(15, 15, 15, 15, 1);
    eg.keyon = 1'b1;
    tk(0); tk(0); tk(0);
    check3("sus.decay_start", 0, 1, 0);
    for (int i = 0; i < 62; i++) tk(i);
    check3("sus.at496", 496, 1, 1);
    tk(0);
    check3("sus.enter", 496, 2, 0);
    stp_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tk(i);
      if (eg.eg_stp) stp_seen = 1;
    end
    check("sus.hold_stp", stp_seen, 0);
    check3("sus.hold", 496, 2, 0);
    eg.eg_type = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tk(i);
      check3($sformatf("sus.creep%0d", i), seq5_lvl[i], 2, seq5_stp[i]);
    end

    // Key-off while a decay step is due; then zero rates freeze the level
    do_reset();
    set_regs(15, 15, 15, 15, 1);
    eg.keyon = 1'b1;
    tk(0); tk(0); tk(0); tk(0);
    check3("koff.pre", 8, 1, 1);
    eg.keyon = 1'b0;
    tk(0);
    check3("koff.release", 8, 3, 0);
    set_regs(0, 0, 15, 0, 0);
    eg.keyon = 1'b1;
    tk(0);
    check3("frz.attack", 8, 0, 0);
    stp_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tk(int'($urandom_range(0, 32767)));
      if (eg.eg_stp) stp_seen = 1;
    end
    check("frz.stp", stp_seen, 0);
    check3("frz.end", 8, 0, 0);

    // Randomized run against the reference model
    do_reset();
    cnt = int'($urandom_range(0, 32767));
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        set_regs(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)));
        eg.ksr_off = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 63) == 0) eg.keyon = ~eg.keyon;
      eg.cen    = ($urandom_range(0, 3) != 0);
      eg.zero   = ($urandom_range(0, 1) != 0);
      eg.eg_cnt = 15'(cnt);
      exp_lvl = 0;
      cyc();
      if (eg.cen && eg.zero) cnt = (cnt + 1) % 32768;
      check("rnd.level", int'(eg.eg_level), m_level);
      check("rnd.state", int'(eg.eg_state), m_state);
      check("rnd.stp",   int'(eg.eg_stp),   m_stp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
